codec_cfg_sequencer: RTL and testbench



---
 rtl/codec_cfg_pkg.sv | 47 ++++
 rtl/codec_cfg_if.sv | 23 ++
 rtl/codec_cfg_rom.sv | 10 +
 rtl/codec_cfg_sequencer.sv | 175 +++++++++++++++++
 tb/tb_codec_cfg_sequencer.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/codec_cfg_pkg.sv
// Shared constants, state encoding and the codec register table
// for the audio codec configuration sequencer.
package codec_cfg_pkg;

  localparam logic [7:0] CODEC_ADDR = 8'h34;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_LOAD,
    ST_REQ,
    ST_WAIT_BEGIN,
    ST_WAIT_END,
    ST_CHECK,
    ST_GAP,
    ST_DONE,
    ST_FAIL
  } cfg_state_t;

  // {reg[6:0], data[8:0]}; the codec reset write goes first
  localparam logic [15:0] R15_RST = {7'd15, 9'h000};
  localparam logic [15:0] R0_VAL  = {7'd0,  9'h017};
  localparam logic [15:0] R1_VAL  = {7'd1,  9'h017};
  localparam logic [15:0] R2_VAL  = {7'd2,  9'h079};
  localparam logic [15:0] R3_VAL  = {7'd3,  9'h079};
  localparam logic [15:0] R4_VAL  = {7'd4,  9'h012};
  localparam logic [15:0] R5_VAL  = {7'd5,  9'h000};
  localparam logic [15:0] R6_VAL  = {7'd6,  9'h000};
  localparam logic [15:0] R7_VAL  = {7'd7,  9'h042};
  localparam logic [15:0] R9_VAL  = {7'd9,  9'h001};

  function automatic logic [15:0] cfg_entry(input logic [3:0] idx);
    case (idx)
      4'd0:    return R15_RST;
      4'd1:    return R0_VAL;
      4'd2:    return R1_VAL;
      4'd3:    return R2_VAL;
      4'd4:    return R3_VAL;
      4'd5:    return R4_VAL;
      4'd6:    return R5_VAL;
      4'd7:    return R6_VAL;
      4'd8:    return R7_VAL;
      4'd9:    return R9_VAL;
      default: return 16'h0000;
    endcase
  endfunction

endpackage

// File: rtl/codec_cfg_if.sv
// Handshake bundle between the sequencer (master) and the
// I2C programmer / system side (slave).
interface codec_cfg_if;
  logic        start;
  logic [23:0] i2c_data;
  logic        go;
  logic        trn_end;
  logic        ack;
  logic [3:0]  mstep;
  logic        busy;
  logic        done;
  logic        error;

  modport master (
    input  start, trn_end, ack,
    output i2c_data, go, mstep, busy, done, error
  );

  modport slave (
    output start, trn_end, ack,
    input  i2c_data, go, mstep, busy, done, error
  );
endinterface

// File: rtl/codec_cfg_rom.sv
// Combinational index -> 24-bit I2C word lookup.
module codec_cfg_rom (
  input  logic [3:0]  idx_i,
  output logic [23:0] word_o
);
  import codec_cfg_pkg::*;

  assign word_o = {CODEC_ADDR, cfg_entry(idx_i)};

endmodule

// File: rtl/codec_cfg_sequencer.sv
// Codec register-write sequencer driving the I2C programmer.
// Define CFG_RETRY_EN to build the per-entry NACK/timeout retry counter.
module codec_cfg_sequencer #(
  parameter int NUM_REGS       = 10,
  parameter int GAP_CYCLES     = 2000,
  parameter int TIMEOUT_CYCLES = 200000,
  parameter int MAX_RETRY      = 3
) (
  input logic         clk,
  input logic         reset,
  codec_cfg_if.master bus
);
  import codec_cfg_pkg::*;

  localparam logic [3:0]  LAST     = 4'(NUM_REGS - 1);
  localparam logic [15:0] GAP_LAST = 16'(GAP_CYCLES - 1);
  localparam logic [17:0] TMO_LAST = 18'(TIMEOUT_CYCLES - 1);
  localparam logic [23:0] WORD0    = {CODEC_ADDR, cfg_entry(4'd0)};

  cfg_state_t  state_q;
  logic [3:0]  mstep_q;
  logic [23:0] data_q;
  logic [23:0] rom_word;
  logic        go_q, busy_q, done_q, error_q, auto_q;
  logic [17:0] tmo_q;
  logic [15:0] gap_q;
  logic        te_m, te_s, ack_m, ack_s;
  logic        tmo_hit, retry_ev, can_retry, run_go, adv;

  always_ff @(posedge clk) begin
    if (reset) begin
      te_m  <= 1'b1;
      te_s  <= 1'b1;
      ack_m <= 1'b1;
      ack_s <= 1'b1;
    end else begin
      te_m  <= bus.trn_end;
      te_s  <= te_m;
      ack_m <= bus.ack;
      ack_s <= ack_m;
    end
  end

  codec_cfg_rom u_rom (
    .idx_i  (mstep_q),
    .word_o (rom_word)
  );

  assign run_go  = (state_q == ST_IDLE) && (bus.start || auto_q);
  assign adv     = (state_q == ST_CHECK) && !ack_s;
  assign tmo_hit = tmo_q >= TMO_LAST;
  // NACK at end of transfer, or a handshake edge that never came
  assign retry_ev = ((state_q == ST_CHECK) && ack_s)
                 || ((state_q == ST_WAIT_BEGIN) && te_s && tmo_hit)
                 || ((state_q == ST_WAIT_END) && !te_s && tmo_hit);

`ifdef CFG_RETRY_EN
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  logic [RW-1:0] retry_q;

  assign can_retry = int'(retry_q) < MAX_RETRY;

  always_ff @(posedge clk) begin
    if (reset) begin
      retry_q <= '0;
    end else if (run_go || adv) begin
      retry_q <= '0;
    end else if (retry_ev && can_retry) begin
      retry_q <= retry_q + RW'(1);
    end
  end
`else
  logic unused_max_retry;
  assign can_retry        = 1'b0;
  assign unused_max_retry = ^MAX_RETRY;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      go_q    <= 1'b0;
      mstep_q <= 4'd0;
      data_q  <= WORD0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      auto_q  <= 1'b1;
      tmo_q   <= '0;
      gap_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (run_go) begin
            auto_q  <= 1'b0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            error_q <= 1'b0;
            mstep_q <= 4'd0;
            state_q <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          data_q  <= rom_word;
          state_q <= ST_REQ;
        end
        ST_REQ: begin
          go_q    <= 1'b1;
          tmo_q   <= '0;
          state_q <= ST_WAIT_BEGIN;
        end
        ST_WAIT_BEGIN: begin
          if (!te_s) begin
            tmo_q   <= '0;
            state_q <= ST_WAIT_END;
          end else if (tmo_q != '1) begin
            tmo_q <= tmo_q + 18'd1;
          end
        end
        ST_WAIT_END: begin
          if (te_s) begin
            tmo_q   <= '0;
            state_q <= ST_CHECK;
          end else if (tmo_q != '1) begin
            tmo_q <= tmo_q + 18'd1;
          end
        end
        ST_CHECK: begin
          go_q <= 1'b0;
          if (!ack_s) begin
            if (mstep_q == LAST) begin
              state_q <= ST_DONE;
            end else begin
              mstep_q <= mstep_q + 4'd1;
              gap_q   <= '0;
              state_q <= ST_GAP;
            end
          end
        end
        ST_GAP: begin
          if (gap_q >= GAP_LAST) begin
            gap_q   <= '0;
            state_q <= ST_LOAD;
          end else if (gap_q != '1) begin
            gap_q <= gap_q + 16'd1;
          end
        end
        ST_DONE: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        ST_FAIL: begin
          error_q <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
      if (retry_ev) begin
        go_q    <= 1'b0;
        tmo_q   <= '0;
        gap_q   <= '0;
        state_q <= can_retry ? ST_GAP : ST_FAIL;
      end
    end
  end

  assign bus.i2c_data = data_q;
  assign bus.go       = go_q;
  assign bus.mstep    = mstep_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.error    = error_q;

endmodule

// File: tb/tb_codec_cfg_sequencer.sv
// Scoreboard bench: a programmer model pops expected words per go
// request, NACKs or hangs on command, and end-of-run status is checked.
module tb_codec_cfg_sequencer;

  logic clk = 1'b0;
  logic reset;

  always #10 clk = ~clk;

  codec_cfg_if bus ();

  codec_cfg_sequencer #(
    .NUM_REGS       (10),
    .GAP_CYCLES     (4),
    .TIMEOUT_CYCLES (64),
    .MAX_RETRY      (3)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  localparam logic [23:0] W [10] = '{
    24'h341E00, 24'h340017, 24'h340217, 24'h340479, 24'h340679,
    24'h340812, 24'h340A00, 24'h340C00, 24'h340E42, 24'h341201
  };

  logic [23:0] exp_q [$];
  int n_chk = 0;
  int n_pass = 0;
  int nxfer = 0;
  int rises = 0;
  int stable_err = 0;
  int nack_idx = -1;
  int nack_left = 0;
  int min_low = 999;
  int low_cnt = 0;
  int exp_n, exp_step, w;
  bit exp_done, exp_err, found;
  bit hang = 1'b0;
  bit go_p = 1'b0;
  bit mon_p = 1'b0;
  bit had_fall = 1'b0;

  task automatic check(string tag, logic [31:0] got, logic [31:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", tag, got, want);
  endtask

  task automatic push_run(int first, int last);
    for (int i = first; i <= last; i++) exp_q.push_back(W[i]);
  endtask

  task automatic wait_idle(string tag);
    for (int i = 0; i < 4000 && bus.busy; i++) @(negedge clk);
    check(tag, bus.busy, 0);
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // go-pulse counter and minimum low time between pulses
  always @(negedge clk) begin
    if (bus.go && !mon_p) begin
      rises++;
      if (had_fall && low_cnt < min_low) min_low = low_cnt;
    end
    if (!bus.go && mon_p) begin
      had_fall = 1'b1;
      low_cnt = 0;
    end
    if (!bus.go) low_cnt++;
    mon_p = bus.go;
  end

  task automatic serve();
    logic [23:0] wd;
    bit nk, ab;
    wd = bus.i2c_data;
    nxfer++;
    if (exp_q.size() == 0) check("sb_extra", exp_q.size(), 1);
    else check("sb_word", wd, exp_q.pop_front());
    nk = (int'(bus.mstep) == nack_idx) && (nack_left > 0);
    if (nk) nack_left--;
    ab = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (!bus.go) begin
        ab = 1'b1;
        break;
      end
      if (i == 1) bus.trn_end = 1'b0;
      if (bus.i2c_data != wd) stable_err++;
    end
    bus.ack = ab ? 1'b1 : nk;
    bus.trn_end = 1'b1;
    if (!ab) for (int i = 0; i < 20 && bus.go; i++) @(negedge clk);
  endtask

  initial begin : programmer
    bus.trn_end = 1'b1;
    bus.ack = 1'b1;
    forever begin
      @(negedge clk);
      if (bus.go && !go_p && !hang) serve();
      go_p = bus.go;
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    reset = 1'b1;
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_go", bus.go, 0);
    check("rst_mstep", bus.mstep, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_error", bus.error, 0);
    check("rst_data", bus.i2c_data, W[0]);

    push_run(0, 9);
    nxfer = 0;
    reset = 1'b0;
    @(negedge clk);
    check("auto_busy", bus.busy, 1);
    check("lat_go0", bus.go, 0);
    @(negedge clk);
    check("lat_go1", bus.go, 0);
    @(negedge clk);
    check("lat_go2", bus.go, 1);
    wait_idle("run1_idle");
    check("run1_done", bus.done, 1);
    check("run1_err", bus.error, 0);
    check("run1_mstep", bus.mstep, 9);
    check("run1_xfers", nxfer, 10);
    check("run1_sb", exp_q.size(), 0);
    check("run1_gap", min_low, 6);

    push_run(0, 9);
    nxfer = 0;
    @(negedge clk);
    pulse_start();
    check("rerun_done_clr", bus.done, 0);
    check("rerun_busy", bus.busy, 1);
    repeat (40) @(negedge clk);
    pulse_start();
    wait_idle("rerun_idle");
    check("rerun_done", bus.done, 1);
    check("rerun_xfers", nxfer, 10);
    check("rerun_mstep", bus.mstep, 9);
    check("rerun_sb", exp_q.size(), 0);

    nack_idx = 3;
    nack_left = 2;
    nxfer = 0;
`ifdef CFG_RETRY_EN
    push_run(0, 3);
    push_run(3, 3);
    push_run(3, 9);
    exp_n = 12; exp_done = 1'b1; exp_err = 1'b0; exp_step = 9;
`else
    push_run(0, 3);
    exp_n = 4; exp_done = 1'b0; exp_err = 1'b1; exp_step = 3;
`endif
    pulse_start();
    wait_idle("nack3_idle");
    check("nack3_xfers", nxfer, exp_n);
    check("nack3_done", bus.done, exp_done);
    check("nack3_err", bus.error, exp_err);
    check("nack3_mstep", bus.mstep, exp_step);
    check("nack3_sb", exp_q.size(), 0);

    nack_idx = 5;
    nack_left = 100;
    nxfer = 0;
`ifdef CFG_RETRY_EN
    push_run(0, 4);
    for (int i = 0; i < 4; i++) push_run(5, 5);
    exp_n = 9;
`else
    push_run(0, 5);
    exp_n = 6;
`endif
    pulse_start();
    wait_idle("nack5_idle");
    check("nack5_xfers", nxfer, exp_n);
    check("nack5_err", bus.error, 1);
    check("nack5_done", bus.done, 0);
    check("nack5_mstep", bus.mstep, 5);
    check("nack5_sb", exp_q.size(), 0);
    nack_idx = -1;
    nack_left = 0;

    hang = 1'b1;
    rises = 0;
    pulse_start();
    for (int i = 0; i < 20 && !bus.go; i++) @(negedge clk);
    w = 0;
    while (bus.go && w < 200) begin
      w++;
      @(negedge clk);
    end
    check("tmo_width", w, 64);
    wait_idle("tmo_idle");
`ifdef CFG_RETRY_EN
    exp_n = 4;
`else
    exp_n = 1;
`endif
    check("tmo_tries", rises, exp_n);
    check("tmo_err", bus.error, 1);
    check("tmo_mstep", bus.mstep, 0);
    hang = 1'b0;

    push_run(0, 4);
    nxfer = 0;
    pulse_start();
    found = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (bus.go && bus.mstep == 4'd4) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("mrst_found", found, 1);
    reset = 1'b1;
    @(negedge clk);
    check("mrst_go", bus.go, 0);
    check("mrst_mstep", bus.mstep, 0);
    check("mrst_done", bus.done, 0);
    check("mrst_busy", bus.busy, 0);
    reset = 1'b0;
    push_run(0, 9);
    @(negedge clk);
    check("mrst_auto", bus.busy, 1);
    wait_idle("mrst_idle");
    check("mrst_fin_done", bus.done, 1);
    check("mrst_fin_mstep", bus.mstep, 9);
    check("mrst_xfers", nxfer, 15);
    check("mrst_sb", exp_q.size(), 0);
    check("data_stable", stable_err, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
